// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES block/word widths, types and a word-select helper
//            used by the ciphertext serializer and its block FIFO.
// Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORD_W          = 32;
  localparam int AES_WORDS_PER_BLOCK = 4;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;

  // Word 0 is the most significant word of the block (MSW-first order).
  function automatic aes_word_t aes_word_sel(input aes_block_t blk, input logic [1:0] idx);
    aes_word_t w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_blk_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aes_blk_fifo
// Purpose  : DEPTH x 128-bit synchronous FIFO with occupancy count. A push
//            into a full FIFO is accepted when a pop happens in the same
//            cycle; a push into a full FIFO without a pop is dropped.
// Revision : 1.0  initial release
// ============================================================================
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  aes_block_t       i_wr_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_level,
  output aes_block_t       o_rd_data
);

  localparam int               c_AW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  aes_block_t         r_mem [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]   r_level;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_level == c_DEPTH);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers (power-of-two depth wraps naturally) and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + CNT_W'(1);
        2'b01:   r_level <= r_level - CNT_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_ct_serializer.sv
`default_nettype none
// ============================================================================
// Module   : aes_ct_serializer
// Purpose  : Captures every 128-bit ciphertext from the non-stallable AES
//            pipeline into a block FIFO and emits it as four 32-bit words
//            (MSW first) on a valid/ready stream. Issues credits so a new
//            encryption only starts when FIFO space is guaranteed.
// Options  : AES_CT_SER_OVF_ERR_EN adds a sticky ovf_err output.
// Revision : 1.0  initial release
// ============================================================================
module aes_ct_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  output logic             can_issue,
  input  aes_block_t       ct_in,
  input  logic             ct_valid,
  output aes_word_t        out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
`ifdef AES_CT_SER_OVF_ERR_EN
  output logic             ovf_err,
`endif
  output logic [CNT_W-1:0] level
);

  localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   c_DEPTH_X  = (CNT_W+1)'(DEPTH);

  logic [1:0]       r_word_idx;
  logic [CNT_W-1:0] r_in_flight;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_level;
  aes_block_t       w_rd_data;
  logic             w_xfer;
  logic             w_pop;

  aes_blk_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (ct_valid),
    .i_wr_data (ct_in),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level),
    .o_rd_data (w_rd_data)
  );

  assign w_xfer    = out_valid & out_ready;
  assign w_pop     = w_xfer & (r_word_idx == 2'd3);

  assign level     = w_level;
  assign out_valid = ~w_empty;
  // Gate to zero when empty so the unreset storage never shows on the bus.
  assign out_data  = out_valid ? aes_word_sel(w_rd_data, r_word_idx) : '0;
  assign out_last  = out_valid & (r_word_idx == 2'd3);
  assign can_issue = ({1'b0, w_level} + {1'b0, r_in_flight}) < c_DEPTH_X;

  // Word index within the head block; wraps to 0 when the block is popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word_idx <= 2'd0;
    end else if (w_xfer) begin
      r_word_idx <= r_word_idx + 2'd1;
    end
  end

  // Encryptions in flight: saturating at 0 (survivors of a reset) and DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_flight <= '0;
    end else if (issue && !ct_valid) begin
      if (r_in_flight < c_DEPTH) r_in_flight <= r_in_flight + CNT_W'(1);
    end else if (ct_valid && !issue) begin
      if (r_in_flight != '0) r_in_flight <= r_in_flight - CNT_W'(1);
    end
  end

`ifdef AES_CT_SER_OVF_ERR_EN
  logic r_ovf_err;
  assign ovf_err = r_ovf_err;

  // Sticky flag: a ciphertext arrived while full and nothing was popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_err <= 1'b0;
    end else if (ct_valid && w_full && !w_pop) begin
      r_ovf_err <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/aes_ct_serializer.md
Name: aes_ct_serializer

Overview:
- Downstream neighbour of the 10-round pipelined AES encryptor. The encryptor produces one 128-bit ciphertext per valid pulse and cannot be stalled.
- This block captures every ciphertext into a FIFO and serializes each one as four 32-bit words on a valid/ready stream.
- It issues credits to the encryptor's issuing logic, so a new block starts only when FIFO space is guaranteed on arrival.

Parameters:
- DEPTH, 8, FIFO entries of 128 bits; power of two, range 2..64.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy and in-flight counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- issue  in  1  upstream starts one encryption this cycle (same signal as the encryptor's enable).
- can_issue  out  1  high when a new issue is guaranteed FIFO space.
- ct_in  in  128  ciphertext from the encryptor.
- ct_valid  in  1  ct_in valid this cycle; single-cycle, no backpressure.
- out_data  out  32  serialized word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the word.
- out_last  out  1  marks the 4th word of a block.
- level  out  CNT_W  number of occupied FIFO entries.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: can_issue=1, out_valid=0, out_last=0, out_data=0, level=0. Write pointer, read pointer, word index and in_flight are all cleared.
- Push:
  - ct_valid=1 and level<DEPTH → write ct_in at the write pointer.
  - The write pointer wraps modulo DEPTH.
- Pop:
  - A word is transferred when out_valid & out_ready.
  - word_idx counts 0..3. out_data = entry[127-32*word_idx -: 32], i.e. MSW first.
  - out_last = out_valid & (word_idx==3).
  - A transfer with word_idx==3 pops the entry, sets word_idx=0 and advances the read pointer (wraps modulo DEPTH).
- out_valid = (level!=0). out_data/out_last come from registered FIFO state (pointers, word_idx), not combinationally from ct_in.
- Latency: ct_valid at cycle N into an empty FIFO → first word has out_valid=1 at N+1.
- Simultaneous push and final-word pop in the same cycle: level is unchanged. A push into a full FIFO that also pops this cycle is accepted.
- Credit counter in_flight:
  - +1 on issue, −1 on ct_valid; unchanged when both occur.
  - Decrement saturates at 0. This covers ciphertexts left in the encryptor pipeline across a reset.
  - Increment saturates at DEPTH.
- can_issue = (level + in_flight) < DEPTH, combinational from registers.
  - issue while can_issue=0 is an upstream protocol violation; in_flight still increments (saturating).
- Overflow: ct_valid while level==DEPTH and no pop this cycle → ct_in dropped, pointers unchanged.
- out_valid must stay high and out_data stable until accepted; out_ready may toggle freely.
- Reset mid-block discards any partially sent entry. No further words of that entry appear after reset.

Optional Feature:
- Macro: AES_CT_SER_OVF_ERR_EN.
- Defined:
  - Extra output port ovf_err (1 bit).
  - Sticky high from the cycle after a dropped ct_valid.
  - Cleared only by rst_n; reset value 0.
- Undefined:
  - The port is absent.
  - Overflow drops silently; all other behaviour is identical.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128, AES_WORD_W=32, AES_WORDS_PER_BLOCK=4.
  - typedef aes_block_t (logic [127:0]), typedef aes_word_t (logic [31:0]).
- One sub-module aes_blk_fifo:
  - Parameterized DEPTH × 128 synchronous FIFO with push, pop, full, empty, level and rd_data.
  - The serializer wraps it with the word index, the credit counter and the output mux.

Test Plan:
1. Single block, out_ready=1: issue, then ct_valid with ct_in=128'h00112233_44556677_8899aabb_ccddeeff. Required response:
   - Words 00112233, 44556677, 8899aabb, ccddeeff on four consecutive cycles starting the cycle after ct_valid.
   - out_last on the 4th word; level returns to 0.
2. Backpressure: out_ready held 0 for 5 cycles, then toggled 1/0. Required response:
   - out_data stable while stalled; exactly 4 transfers in order.
   - No duplicate or skipped word.
3. Credits: DEPTH=8, out_ready=0, issue on 8 cycles. Required response:
   - can_issue falls after the 8th issue.
   - 8 ct_valid pulses fill level to 8.
   - can_issue stays 0 until a full block is popped, then returns to 1.
4. Simultaneous events:
   - level=DEPTH with the final word transferring in the same cycle as ct_valid → new block accepted, level stays DEPTH.
   - issue in the same cycle as ct_valid → in_flight unchanged.
5. Overflow: level=DEPTH, out_ready=0, ct_valid=1. Required response:
   - Data dropped; FIFO contents unchanged.
   - ovf_err=1 next cycle when AES_CT_SER_OVF_ERR_EN is defined; port absent otherwise.
6. Reset mid-block: rst_n=0 after word 2 of a block. Required response:
   - Next cycle out_valid=0, level=0, can_issue=1.
   - A post-reset ct_valid with in_flight=0 is accepted; in_flight stays 0 and a full 4-word block is emitted.
